carfield_periph_apb_demux: RTL and testbench
============================================

// Module: carfield_periph_apb_demux
// PURPOSE
//  Registered APB demultiplexer feeding the peripheral APB slaves in the 0x2000_1000..0x2000_9FFF window
//  (CAN, system timer, advanced timer, watchdog, HyperBus cfg). Decodes each upstream access against the
//  carfield_configuration map and forwards it to exactly one slave. Unmapped/disabled accesses get PSLVERR.
//  Hung slaves are abandoned after a timeout. Sits directly downstream of the peripheral AXI->APB bridge.
// PARAMETERS
//  NumSlaves     5        slave ports; idx 0 Can, 1 SystemTimer, 2 SystemAdvancedTimer, 3 SystemWatchdog, 4 HyperBus
//  AddrWidth     32       APB address width
//  DataWidth     32       APB data width; strobe width DataWidth/8
//  SlaveEnMask   5'h1F    bit i=0: slave i is treated as unmapped (bit0 tied to CanEnable at top)
//  TimeoutCycles 256      max ACCESS cycles without m_pready before abort; >=2
//  ErrData       32'hBADCAB1E  s_prdata_o value on decode error or timeout
// PORTS
//  clk_i        in  1             clock
//  rst_i        in  1             synchronous, active-high reset
//  s_psel_i     in  1             upstream APB select
//  s_penable_i  in  1             upstream APB enable
//  s_pwrite_i   in  1             upstream write
//  s_paddr_i    in  AddrWidth     upstream address
//  s_pwdata_i   in  DataWidth     upstream write data
//  s_pstrb_i    in  DataWidth/8   upstream byte strobes
//  s_pready_o   out 1             upstream ready (1-cycle pulse)
//  s_prdata_o   out DataWidth     upstream read data, valid with s_pready_o
//  s_pslverr_o  out 1             upstream error, valid with s_pready_o
//  m_psel_o     out NumSlaves     one-hot slave select
//  m_penable_o  out 1             shared enable
//  m_pwrite_o, m_paddr_o, m_pwdata_o, m_pstrb_o  out  1/AddrWidth/DataWidth/DataWidth/8  shared, latched copies
//  m_prdata_i   in  NumSlaves*DataWidth  slave read data, slave i at [i*DataWidth +: DataWidth]
//  m_pready_i   in  NumSlaves     slave ready
//  m_pslverr_i  in  NumSlaves     slave error
//  timeout_o    out 1             1-cycle pulse when a slave access is aborted
//  err_cnt_o    out 8             saturating count of decode errors + timeouts
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0, err_cnt_o=0, timeout counter=0. Applies mid-transaction, no completion.
//  - Decode: hit i iff SlaveEnMask[i] && base_i <= addr < base_i+size_i. Maps do not overlap.
//    m_paddr_o forwards the full address, not an offset.
//  - FSM IDLE->SETUP->ACCESS->RESP->IDLE.
//    IDLE: on s_psel_i && !s_penable_i, latch addr/wdata/strb/write/idx.
//      Hit: ->SETUP. Miss: ->RESP with err=1, rdata=ErrData, err_cnt+1.
//    SETUP: m_psel_o[idx]=1, m_penable_o=0, one cycle; ->ACCESS.
//    ACCESS: m_psel_o[idx]=1, m_penable_o=1, counter increments.
//      On m_pready_i[idx]: latch m_prdata/m_pslverr[idx]; ->RESP.
//      On counter==TimeoutCycles-1 with no ready: drop psel/penable next cycle, timeout_o=1,
//        err=1, rdata=ErrData, err_cnt+1; ->RESP.
//    RESP: s_pready_o=1 for exactly one cycle with latched rdata/err; ->IDLE, counter cleared.
//  - Latency from upstream setup cycle T0: hit with zero-wait slave -> s_pready_o at T3;
//    miss -> s_pready_o at T1. Each slave wait state adds 1 cycle.
//  - Outside RESP, s_prdata_o=0 and s_pslverr_o=0. m_p* data outputs hold latched values; m_psel_o=0 outside SETUP/ACCESS.
//  - Write data is never returned. s_prdata_o=0 on a successful write.
//  - Upstream dropping s_psel_i mid-transfer (protocol violation): downstream transfer still completes,
//    RESP still pulses. New setups are only sampled in IDLE.
//  - m_pready_i of non-selected slaves is ignored. err_cnt_o saturates at 8'hFF.
//  - A ready and a timeout in the same cycle: ready wins, no timeout.
// TESTING
//  1 Read 0x2000_4008, slave1 pready at first ACCESS cycle with rdata 0x1234_5678 ->
//    m_psel_o=5'b00010 at T1, s_pready_o at T3, s_prdata_o=0x12345678, pslverr=0.
//  2 Write 0x2000_9000 data 0xA5A5_0001 strb 4'hF, slave4 with 3 wait states ->
//    m_pwdata_o/m_pstrb_o held through ACCESS, s_pready_o at T6, pslverr=0.
//  3 Read 0x2000_2000 (gap) and 0x2000_1000 with SlaveEnMask=5'h1E ->
//    both s_pready_o at T1, pslverr=1, rdata=0xBADCAB1E, m_psel_o stays 0, err_cnt_o=2.
//  4 Read 0x2000_7000, slave3 never ready, TimeoutCycles=256 ->
//    timeout_o pulses once, psel dropped, s_pready_o with pslverr=1, rdata ErrData. Next access to slave0 succeeds.
//  5 rst_i asserted in ACCESS, then 300 back-to-back accesses to 0x2000_3000 ->
//    all outputs 0 after the reset edge and no s_pready_o for the aborted transfer. err_cnt_o saturates at 8'hFF.
//  6 Slave2 asserts pready and pslverr at the timeout cycle ->
//    no timeout_o, s_pslverr_o=1, err_cnt_o unchanged.

Source files
------------

// File: rtl/carfield_periph_apb_demux.sv
// Registered APB demultiplexer for the Carfield peripheral window 0x2000_1000..0x2000_9FFF.
// Each upstream access is decoded, replayed to exactly one slave and answered with a
// one-cycle s_pready_o pulse. Unmapped or disabled targets and hung slaves answer with
// PSLVERR and ErrData. An 8-bit saturating counter records how many accesses failed.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for an upstream setup phase
// SETUP  | slave setup phase: psel high, penable low
// ACCESS | slave access phase: waiting for pready, timeout counter runs
// RESP   | one-cycle upstream response with latched rdata/err
module carfield_periph_apb_demux #(
   parameter int unsigned            NumSlaves     = 5,
   parameter int unsigned            AddrWidth     = 32,
   parameter int unsigned            DataWidth     = 32,
   parameter logic [NumSlaves-1:0]   SlaveEnMask   = '1,
   parameter int unsigned            TimeoutCycles = 256,
   parameter logic [DataWidth-1:0]   ErrData       = DataWidth'(32'hBADC_AB1E)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           s_psel_i,
   input  logic                           s_penable_i,
   input  logic                           s_pwrite_i,
   input  logic [AddrWidth-1:0]           s_paddr_i,
   input  logic [DataWidth-1:0]           s_pwdata_i,
   input  logic [DataWidth/8-1:0]         s_pstrb_i,
   output logic                           s_pready_o,
   output logic [DataWidth-1:0]           s_prdata_o,
   output logic                           s_pslverr_o,
   output logic [NumSlaves-1:0]           m_psel_o,
   output logic                           m_penable_o,
   output logic                           m_pwrite_o,
   output logic [AddrWidth-1:0]           m_paddr_o,
   output logic [DataWidth-1:0]           m_pwdata_o,
   output logic [DataWidth/8-1:0]         m_pstrb_o,
   input  logic [NumSlaves*DataWidth-1:0] m_prdata_i,
   input  logic [NumSlaves-1:0]           m_pready_i,
   input  logic [NumSlaves-1:0]           m_pslverr_i,
   output logic                           timeout_o,
   output logic [7:0]                     err_cnt_o
);

   localparam int unsigned IdxW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
   localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
   localparam logic [AddrWidth-1:0] SlaveSize = AddrWidth'(32'h0000_1000);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   // Carfield peripheral map: CAN, system timer, advanced timer, watchdog, HyperBus cfg.
   // Slots beyond the map get an all-ones base, which can never match a 4 KiB range.
   function automatic logic [AddrWidth-1:0] slave_base(input int unsigned i);
      case (i)
         0:       slave_base = AddrWidth'(32'h2000_1000);
         1:       slave_base = AddrWidth'(32'h2000_4000);
         2:       slave_base = AddrWidth'(32'h2000_5000);
         3:       slave_base = AddrWidth'(32'h2000_7000);
         4:       slave_base = AddrWidth'(32'h2000_9000);
         default: slave_base = '1;
      endcase
   endfunction

   logic [1:0]             state_q;
   logic [IdxW-1:0]        idx_q;
   logic [CntW-1:0]        cnt_q;
   logic [DataWidth-1:0]   rdata_q;
   logic                   err_q;
   logic                   timeout_q;
   logic [7:0]             err_cnt_q;
   logic                   pwrite_q;
   logic [AddrWidth-1:0]   paddr_q;
   logic [DataWidth-1:0]   pwdata_q;
   logic [DataWidth/8-1:0] pstrb_q;

   logic                   hit;
   logic [IdxW-1:0]        hit_idx;
   logic                   sel_ready;
   logic                   sel_err;
   logic [DataWidth-1:0]   sel_rdata;

   // Address decode of the live upstream address; maps never overlap, so at most one hit.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NumSlaves; i++) begin
         if (SlaveEnMask[i] && (s_paddr_i >= slave_base(i)) &&
             (s_paddr_i < slave_base(i) + SlaveSize)) begin
            hit     = 1'b1;
            hit_idx = IdxW'(i);
         end
      end
   end

   assign sel_ready = m_pready_i[idx_q];
   assign sel_err   = m_pslverr_i[idx_q];
   assign sel_rdata = m_prdata_i[DataWidth*idx_q +: DataWidth];

   // Transfer sequencing, request latching, timeout and error accounting.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         err_cnt_q <= '0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s_psel_i && !s_penable_i) begin
                  pwrite_q <= s_pwrite_i;
                  paddr_q  <= s_paddr_i;
                  pwdata_q <= s_pwdata_i;
                  pstrb_q  <= s_pstrb_i;
                  idx_q    <= hit_idx;
                  cnt_q    <= '0;
                  if (hit) begin
                     rdata_q <= '0;
                     err_q   <= 1'b0;
                     state_q <= SETUP;
                  end else begin
                     rdata_q <= ErrData;
                     err_q   <= 1'b1;
                     state_q <= RESP;
                     if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                  end
               end
            end
            SETUP: state_q <= ACCESS;
            ACCESS: begin
               // A ready in the last allowed cycle still completes normally.
               if (sel_ready) begin
                  rdata_q <= pwrite_q ? '0 : sel_rdata;
                  err_q   <= sel_err;
                  state_q <= RESP;
               end else if (cnt_q == CntLast) begin
                  rdata_q   <= ErrData;
                  err_q     <= 1'b1;
                  timeout_q <= 1'b1;
                  state_q   <= RESP;
                  if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // One-hot slave select, only driven while the slave transfer is in flight.
   always_comb begin
      m_psel_o = '0;
      if ((state_q == SETUP) || (state_q == ACCESS)) m_psel_o[idx_q] = 1'b1;
   end

   assign m_penable_o = (state_q == ACCESS);
   assign m_pwrite_o  = pwrite_q;
   assign m_paddr_o   = paddr_q;
   assign m_pwdata_o  = pwdata_q;
   assign m_pstrb_o   = pstrb_q;

   assign s_pready_o  = (state_q == RESP);
   assign s_prdata_o  = (state_q == RESP) ? rdata_q : '0;
   assign s_pslverr_o = (state_q == RESP) ? err_q : 1'b0;
   assign timeout_o   = timeout_q;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_carfield_periph_apb_demux.sv
// Directed bench for carfield_periph_apb_demux. A transaction-level model derives, for every
// cycle of each access, what the DUT outputs must be from the address map and latency rules.
// A second instance with CAN disabled covers the enable mask.
module tb_carfield_periph_apb_demux;

   localparam int          Tmo     = 256;
   localparam logic [31:0] ErrWord = 32'hBADC_AB1E;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst       = 1'b1;
   logic         s_psel    = 1'b0;
   logic         s_penable = 1'b0;
   logic         s_pwrite  = 1'b0;
   logic [31:0]  s_paddr   = '0;
   logic [31:0]  s_pwdata  = '0;
   logic [3:0]   s_pstrb   = '0;
   logic [159:0] m_prdata  = '0;
   logic [4:0]   m_pready  = '0;
   logic [4:0]   m_pslverr = '0;

   logic a_pready, a_pslverr, a_penable, a_pwrite, a_timeout;
   logic [31:0] a_prdata, a_paddr, a_pwdata;
   logic [4:0] a_psel;
   logic [3:0] a_pstrb;
   logic [7:0] a_cnt;

   logic b_pready, b_pslverr, b_penable, b_pwrite, b_timeout;
   logic [31:0] b_prdata, b_paddr, b_pwdata;
   logic [4:0] b_psel;
   logic [3:0] b_pstrb;
   logic [7:0] b_cnt;

   carfield_periph_apb_demux dut (
      .clk_i(clk), .rst_i(rst),
      .s_psel_i(s_psel), .s_penable_i(s_penable), .s_pwrite_i(s_pwrite),
      .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
      .s_pready_o(a_pready), .s_prdata_o(a_prdata), .s_pslverr_o(a_pslverr),
      .m_psel_o(a_psel), .m_penable_o(a_penable), .m_pwrite_o(a_pwrite),
      .m_paddr_o(a_paddr), .m_pwdata_o(a_pwdata), .m_pstrb_o(a_pstrb),
      .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
      .timeout_o(a_timeout), .err_cnt_o(a_cnt)
   );

   carfield_periph_apb_demux #(.SlaveEnMask(5'h1E)) dut_nocan (
      .clk_i(clk), .rst_i(rst),
      .s_psel_i(s_psel), .s_penable_i(s_penable), .s_pwrite_i(s_pwrite),
      .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
      .s_pready_o(b_pready), .s_prdata_o(b_prdata), .s_pslverr_o(b_pslverr),
      .m_psel_o(b_psel), .m_penable_o(b_penable), .m_pwrite_o(b_pwrite),
      .m_paddr_o(b_paddr), .m_pwdata_o(b_pwdata), .m_pstrb_o(b_pstrb),
      .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
      .timeout_o(b_timeout), .err_cnt_o(b_cnt)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int cur_k = -1;
   logic chk_en  = 1'b0;
   logic b_track = 1'b0;

   logic        e_pready, e_pslverr, e_penable, e_pwrite, e_timeout;
   logic [31:0] e_prdata, e_paddr, e_pwdata;
   logic [4:0]  e_psel;
   logic [3:0]  e_pstrb;
   logic [7:0]  e_cnt;

   int          resp_k      = -1;
   int          resp_seen   = 0;
   int          tmo_pulses  = 0;
   int          b_resp_cnt  = 0;
   int          b_psel_seen = 0;
   logic [31:0] resp_data   = '0;
   logic        resp_err    = 1'b0;
   logic [4:0]  psel_k1     = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d k=%0d got=%h want=%h", name, cyc, cur_k, act, exp);
      end
   endtask

   // Peripheral page map: 4 KiB pages at 0x2000_1000, _4000, _5000, _7000, _9000.
   function automatic int map_idx(input logic [31:0] a);
      case (a[31:12])
         20'h20001: map_idx = 0;
         20'h20004: map_idx = 1;
         20'h20005: map_idx = 2;
         20'h20007: map_idx = 3;
         20'h20009: map_idx = 4;
         default:   map_idx = -1;
      endcase
   endfunction

   task automatic reset_model();
      e_pready = 1'b0; e_pslverr = 1'b0; e_penable = 1'b0; e_pwrite = 1'b0; e_timeout = 1'b0;
      e_prdata = '0; e_paddr = '0; e_pwdata = '0; e_psel = '0; e_pstrb = '0; e_cnt = '0;
      cur_k = -1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("s_pready",  32'(a_pready),  32'(e_pready));
         chk("s_prdata",  a_prdata,       e_prdata);
         chk("s_pslverr", 32'(a_pslverr), 32'(e_pslverr));
         chk("m_psel",    32'(a_psel),    32'(e_psel));
         chk("m_penable", 32'(a_penable), 32'(e_penable));
         chk("m_pwrite",  32'(a_pwrite),  32'(e_pwrite));
         chk("m_paddr",   a_paddr,        e_paddr);
         chk("m_pwdata",  a_pwdata,       e_pwdata);
         chk("m_pstrb",   32'(a_pstrb),   32'(e_pstrb));
         chk("timeout",   32'(a_timeout), 32'(e_timeout));
         chk("err_cnt",   32'(a_cnt),     32'(e_cnt));
         if (a_pready) begin
            resp_k    = cur_k;
            resp_data = a_prdata;
            resp_err  = a_pslverr;
            resp_seen++;
         end
         if (a_timeout) tmo_pulses++;
         if (cur_k == 1) psel_k1 = a_psel;
      end
      if (b_track) begin
         if (b_pready) begin
            b_resp_cnt++;
            chk("nocan_latency", cur_k, 1);
            chk("nocan_rdata", b_prdata, ErrWord);
            chk("nocan_slverr", 32'(b_pslverr), 1);
         end
         if (b_psel != 5'b0) b_psel_seen++;
      end
   end

   // One upstream access. Cycle k=0 is the setup cycle; the model places the response at
   // k=1 for a miss, k=3+waits for a hit, k=2+Tmo for an abandoned slave (waits >= Tmo).
   task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] st, input int waits, input logic [31:0] rd,
                       input logic serr, input bit drop, input int rst_at);
      int         idx;
      bit         hit;
      bit         tmo;
      int         lat;
      logic [4:0] msk;
      idx = map_idx(addr);
      hit = (idx >= 0);
      tmo = hit && (waits >= Tmo);
      lat = !hit ? 1 : (tmo ? 2 + Tmo : 3 + waits);
      msk = hit ? 5'(1 << idx) : 5'b0;
      s_paddr  = addr;
      s_pwrite = wr;
      s_pwdata = wd;
      s_pstrb  = st;
      for (int k = 0; k <= lat; k++) begin
         cur_k     = k;
         s_psel    = (k == 0) || !drop;
         s_penable = (k != 0) && !drop;
         for (int i = 0; i < 5; i++) m_prdata[i*32 +: 32] = $urandom;
         m_pready  = 5'($urandom) & ~msk;
         m_pslverr = 5'($urandom);
         if (hit && !tmo && (k == lat - 1)) begin
            m_pready  = m_pready | msk;
            m_pslverr = (m_pslverr & ~msk) | (serr ? msk : 5'b0);
            m_prdata[idx*32 +: 32] = rd;
         end
         e_psel    = (hit && k >= 1 && k <= lat - 1) ? msk : 5'b0;
         e_penable = hit && (k >= 2) && (k <= lat - 1);
         if (k >= 1) begin
            e_paddr  = addr;
            e_pwrite = wr;
            e_pwdata = wd;
            e_pstrb  = st;
         end
         e_pready  = (k == lat);
         e_timeout = (k == lat) && tmo;
         e_pslverr = (k == lat) && (!hit || tmo || serr);
         e_prdata  = (k != lat) ? 32'h0 : (!hit || tmo) ? ErrWord : wr ? 32'h0 : rd;
         if ((k == lat) && (!hit || tmo) && (e_cnt != 8'hFF)) e_cnt = e_cnt + 8'd1;
         if (k == rst_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            reset_model();
            s_psel = 1'b0; s_penable = 1'b0; m_pready = '0; m_pslverr = '0;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      s_psel = 1'b0; s_penable = 1'b0;
      m_pready = 5'($urandom); m_pslverr = 5'($urandom);
      e_psel = '0; e_penable = 1'b0; e_pready = 1'b0; e_prdata = '0;
      e_pslverr = 1'b0; e_timeout = 1'b0;
      cur_k = -1;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      // Gap miss and CAN access; the CAN-disabled instance must miss both.
      b_track = 1'b1;
      xfer(32'h2000_2000, 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0, -1);
      xfer(32'h2000_1000, 1'b0, 32'h0, 4'hF, 0, 32'hCAFE_0001, 1'b0, 1'b0, -1);
      idle(1);
      b_track = 1'b0;
      chk("nocan_err_cnt", 32'(b_cnt), 2);
      chk("nocan_resp_cnt", b_resp_cnt, 2);
      chk("nocan_psel_seen", b_psel_seen, 0);

      // Zero-wait read of the system timer.
      xfer(32'h2000_4008, 1'b0, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0, 1'b0, -1);
      chk("t1_latency", resp_k, 3);
      chk("t1_rdata", resp_data, 32'h1234_5678);
      chk("t1_slverr", 32'(resp_err), 0);
      chk("t1_psel_T1", 32'(psel_k1), 32'h2);

      // HyperBus write with three wait states; read data must not come back.
      xfer(32'h2000_9000, 1'b1, 32'hA5A5_0001, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, -1);
      chk("t2_latency", resp_k, 6);
      chk("t2_rdata", resp_data, 32'h0);
      idle(1);

      // Upstream drops psel mid-transfer; the slave transfer still completes.
      xfer(32'h2000_5010, 1'b0, 32'h0, 4'h3, 1, 32'h0BAD_F00D, 1'b0, 1'b1, -1);
      chk("drop_rdata", resp_data, 32'h0BAD_F00D);
      // Slave-reported error on a write.
      xfer(32'h2000_4100, 1'b1, 32'h0000_0001, 4'h1, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
      chk("werr_slverr", 32'(resp_err), 1);
      idle(2);

      // Watchdog never answers, then CAN works again.
      tmo_pulses = 0;
      xfer(32'h2000_7000, 1'b0, 32'h0, 4'hF, 1000, 32'h0, 1'b0, 1'b0, -1);
      chk("t4_tmo_pulses", tmo_pulses, 1);
      chk("t4_rdata", resp_data, ErrWord);
      chk("t4_slverr", 32'(resp_err), 1);
      chk("t4_latency", resp_k, 258);
      xfer(32'h2000_1004, 1'b0, 32'h0, 4'hF, 2, 32'h5555_AAAA, 1'b0, 1'b0, -1);
      chk("t4_next_rdata", resp_data, 32'h5555_AAAA);
      chk("t4_next_slverr", 32'(resp_err), 0);

      // Ready plus slave error in the very last allowed ACCESS cycle.
      tmo_pulses = 0;
      xfer(32'h2000_5000, 1'b0, 32'h0, 4'hF, 255, 32'h600D_0006, 1'b1, 1'b0, -1);
      chk("t6_tmo_pulses", tmo_pulses, 0);
      chk("t6_slverr", 32'(resp_err), 1);
      chk("t6_err_cnt", 32'(a_cnt), 2);
      idle(1);

      // Reset during ACCESS aborts silently, then saturate the error counter.
      resp_seen = 0;
      xfer(32'h2000_4000, 1'b0, 32'h0, 4'hF, 5, 32'h1, 1'b0, 1'b0, 3);
      idle(4);
      chk("t5_no_resp", resp_seen, 0);
      chk("t5_cnt_cleared", 32'(a_cnt), 0);
      for (int i = 0; i < 300; i++)
         xfer(32'h2000_3000 + 32'(i * 4), 1'b0, 32'h0, 4'hF, 0, 32'h0, 1'b0, 1'b0, -1);
      idle(2);
      chk("t5_saturated", 32'(a_cnt), 32'hFF);
      chk("t5_resp_count", resp_seen, 300);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
